// File: rtl/mag_sqrt_unit_if.sv
// Purpose: sample/result handshake bundle between the magnitude master and mag_sqrt_unit.
// Latency: none; this is wiring only.
// Backpressure: in_ready stalls sample pushes, and out_ready holds the result.
// Signals: in_valid/in_ready/in_data carry samples in; out_valid/out_ready/out_data carry results out.
//          busy is a status flag.
// Modports: master = magnitude master side, slave = mag_sqrt_unit side.
interface mag_sqrt_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int RESULT_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [RESULT_WIDTH-1:0] out_data;
  logic                    busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mag_sqrt_unit.sv
// Purpose: |z| = floor(sqrt(re^2 + im^2)) for one packed complex sample {re[31:16], im[15:0]}.
// Latency: 18 cycles from accept to out_valid; one sample in flight; best case one sample per 19 cycles.
// Backpressure: in_ready is low unless IDLE; the result holds in DONE until out_ready is seen.
// Ports: csi_clock_clk (clock), csi_clock_reset (synchronous, active-high),
//        io (mag_sqrt_unit_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy).
// Build option: define MAG_ROUND_EN to round the result to nearest instead of flooring it.
module mag_sqrt_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int RESULT_WIDTH = 32
) (
  input  logic               csi_clock_clk,
  input  logic               csi_clock_reset,
  mag_sqrt_unit_if.slave     io
);

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t                  state_q,     state_d;
  logic [DATA_WIDTH-1:0]   sample_q,    sample_d;
  logic [31:0]             rad_q,       rad_d;
  logic [15:0]             root_q,      root_d;
  logic [17:0]             rem_q,       rem_d;
  logic [3:0]              cnt_q,       cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [RESULT_WIDTH-1:0] out_data_q,  out_data_d;

  logic [15:0] re_abs, im_abs;
  logic [31:0] re_sq, im_sq;
  logic [17:0] rem_sh, trial, rem_next;
  logic [15:0] root_next, result;

  // Datapath for one square-root digit plus the magnitude squaring.
  always_comb begin
    // Two's complement abs; -32768 maps to 0x8000 = 32768 as unsigned.
    re_abs = sample_q[31] ? (~sample_q[31:16] + 16'd1) : sample_q[31:16];
    im_abs = sample_q[15] ? (~sample_q[15:0]  + 16'd1) : sample_q[15:0];
    re_sq  = 32'(re_abs) * 32'(re_abs);
    im_sq  = 32'(im_abs) * 32'(im_abs);

    // The remainder never exceeds 2*root, so 18 bits hold the shifted value for all 16 steps.
    rem_sh = (rem_q << 2) | {16'd0, rad_q[31:30]};
    trial  = {root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_next  = rem_sh - trial;
      root_next = (root_q << 1) | 16'd1;
    end else begin
      rem_next  = rem_sh;
      root_next = root_q << 1;
    end

`ifdef MAG_ROUND_EN
    // N - r^2 > r is equivalent to sqrt(N) >= r + 0.5.
    result = root_next + ((rem_next > {2'b00, root_next}) ? 16'd1 : 16'd0);
`else
    result = root_next;
`endif
  end

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    rad_d       = rad_q;
    root_d      = root_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          sample_d = io.in_data;
          state_d  = SQUARE;
        end
      end
      SQUARE: begin
        // The sum peaks at 2^31, so it cannot overflow 32 bits.
        rad_d   = re_sq + im_sq;
        root_d  = '0;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ROOT;
      end
      ROOT: begin
        rad_d  = rad_q << 2;
        rem_d  = rem_next;
        root_d = root_next;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          out_data_d  = RESULT_WIDTH'(result);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge csi_clock_clk) begin
    if (csi_clock_reset) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      rad_q       <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      rad_q       <= rad_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE) && !csi_clock_reset;
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;

endmodule
